adc_conversion_sequencer: RTL
=============================

# adc_conversion_sequencer

Initiator for the SAR ADC `enable`/`done` handshake: on one `start`, it steps an analog mux across `channels` column inputs. For each channel it waits for mux settling, runs one conversion, and captures the result. It delivers each `{channel, result}` word on a valid/ready stream toward the readout FIFO. It sits between the frame controller and the per-column SAR ADC, and owns conversion ordering, timeout and backpressure.

## Interface
- `resolution`, 8, ADC result width in bits.
- `channels`, 4, number of mux inputs converted per frame (≥2).
- `settle_cycles`, 2, cycles between a mux change and `adc_enable` rising (≥1).
- `timeout_cycles`, 64, maximum cycles `adc_enable` stays high without `adc_done`.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (`0` = reset).
- `start`  in  1  level-sampled request for one frame; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until frame end.
- `frame_done`  out  1  one-cycle pulse when the last channel word is accepted.
- `channel_select`  out  `$clog2(channels)`  analog mux select.
- `adc_enable`  out  1  conversion request to the SAR ADC.
- `adc_done`  in  1  SAR conversion complete; `adc_result` is stable while high.
- `adc_result`  in  `resolution`  SAR code.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_data`  out  `resolution`  captured code, or 0 on timeout.
- `out_channel`  out  `$clog2(channels)`  channel index of `out_data`.
- `out_error`  out  1  word produced by a timeout.
- `error_sticky`  out  1  set by any timeout; cleared only by an accepted `start`.

## Operation
- Reset value of every output is 0. The state is IDLE and the counters are 0.
- IDLE: `start=1` → SETTLE, channel 0, settle counter cleared, `error_sticky` cleared.
- SETTLE: counts `settle_cycles`. Then, if the output register is free, or is being drained this cycle, go to CONVERT. Otherwise hold with `adc_enable=0`.
- CONVERT: `adc_enable=1` and the timeout counter increments.
  - First cycle with `adc_done=1`: capture `adc_result` into the output register with `out_error=0`, then go to RELEASE.
  - Counter reaches `timeout_cycles`: load data 0 with `out_error=1`, set `error_sticky`, go to RELEASE.
- RELEASE: `adc_enable=0`. Wait for `adc_done=0` (four-phase handshake).
  - If this was the last channel, go to DRAIN.
  - Otherwise increment `channel_select` and go to SETTLE.
- DRAIN: wait for the final word to be accepted. Pulse `frame_done`, drop `busy`, return to IDLE.
- Output register: a single entry. `out_valid` is set on capture and cleared on acceptance. `out_data`, `out_channel` and `out_error` are held stable while `out_valid & !out_ready`.
- `start` outside IDLE is ignored, with no queuing. `start` held high through frame end begins a new frame on the cycle after `frame_done`.
- `adc_done` high on entry to CONVERT counts as done in that first cycle. It is the SAR's responsibility not to leave a stale done.
- Asynchronous reset mid-frame: every output returns to 0 immediately, including `adc_enable`. Any pending word is discarded.
- Counters are sized with `$clog2` of their limit plus 1. `channel_select` never exceeds `channels-1`, with no wrap inside a frame.

## Timing
- `start` sampled at edge t:
  - `busy=1` and `channel_select=0` from t+1.
  - `adc_enable` rises at t+1+`settle_cycles`.
- `adc_done` sampled high at edge k:
  - `out_valid=1` and `adc_enable=0` from k+1.
  - The next channel's `channel_select` appears the cycle after `adc_done` is sampled low.
- With `out_ready=1` held, there is no stall. Per channel, the frame costs `settle_cycles` + SAR latency + 2 cycles.
- `frame_done` asserts on the cycle after the last word's acceptance edge, coincident with `busy` falling.
- Timeout: `adc_enable` high for exactly `timeout_cycles` cycles, then low on the next cycle.

## Structure
- Shared package `adc_pkg` holds:
  - the state enum `seq_state_t` (IDLE, SETTLE, CONVERT, RELEASE, DRAIN);
  - the default constants for `resolution` and `channels`.
- One sub-module, `cycle_timer`: a parameterised load/count/expire counter, instantiated for settle and for timeout.
- The output register and FSM are in the top module.

## Test plan
- `channels=4`, SAR model with 9-cycle latency, inputs 0.0/0.3/0.6/1.2 V at 1.2 V reference, `out_ready=1` → words (0,0x00), (1,0x40), (2,0x80), (3,0xFF) in order; one `frame_done` pulse; `error_sticky=0`.
- Same, with `out_ready` low for 20 cycles after the first word → `adc_enable` for channel 1 does not rise until the word is accepted; all four words are delivered and none is lost.
- SAR model never asserts done on channel 2, `timeout_cycles=64` → `adc_enable` high for exactly 64 cycles; word (2,0x00,`out_error=1`); `error_sticky=1`; channel 3 still converts.
- `start` pulsed again while `busy` → ignored. A single frame of 4 words is produced.
- `reset` driven low during CONVERT of channel 1 → all outputs are 0 in the same cycle; a following `start` begins again at channel 0.
- `adc_done` held high for 5 cycles after capture → the sequencer stays in RELEASE, and `channel_select` advances only after `adc_done` falls.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion sequencer.
//   seq_state_t        : sequencer FSM states
//   DEFAULT_RESOLUTION : default SAR code width
//   DEFAULT_CHANNELS   : default number of mux inputs per frame
package adc_pkg;

    localparam int DEFAULT_RESOLUTION = 8;
    localparam int DEFAULT_CHANNELS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        RELEASE,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter used for the mux settle delay and the SAR timeout.
// While `run` is low the count is held at 0. While `run` is high it counts
// one step per cycle up to LIMIT-1 and then holds there. `expired` is high
// during the LIMIT-th cycle of a run and stays high while the run continues.
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-low reset
//   run     in  count enable; low clears the count
//   expired out count has reached LIMIT-1
module cycle_timer #(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int            W    = $clog2(LIMIT) + 1;
    localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/adc_conversion_sequencer.sv
// Frame sequencer for a per-column SAR ADC. One accepted `start` walks the
// analog mux over all channels: settle, request a conversion, capture the
// code (or a zero error word on timeout), complete the four-phase
// enable/done handshake, then move on. Words leave through a single-entry
// valid/ready output register; the next conversion is not requested until
// that register is free, so backpressure never drops a word.
//   clk, reset            clock / asynchronous active-low reset
//   start                 frame request, honoured only in IDLE
//   busy, frame_done      frame in progress / end-of-frame pulse
//   channel_select        analog mux select
//   adc_enable, adc_done  SAR handshake; adc_result valid while adc_done
//   out_valid/out_ready   output stream handshake
//   out_data, out_channel captured code and its channel
//   out_error             word produced by a timeout
//   error_sticky          any timeout since the last accepted start
module adc_conversion_sequencer
    import adc_pkg::*;
#(
    parameter int resolution     = DEFAULT_RESOLUTION,
    parameter int channels       = DEFAULT_CHANNELS,
    parameter int settle_cycles  = 2,
    parameter int timeout_cycles = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(channels)-1:0] channel_select,
    output logic                        adc_enable,
    input  logic                        adc_done,
    input  logic [resolution-1:0]       adc_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [resolution-1:0]       out_data,
    output logic [$clog2(channels)-1:0] out_channel,
    output logic                        out_error,
    output logic                        error_sticky
);

    localparam int               CH_W    = $clog2(channels);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(channels - 1);

    seq_state_t state, state_next;

    logic settle_expired;
    logic timeout_expired;
    logic accept;
    logic reg_free;
    logic last_ch;
    logic capture;
    logic advance;
    logic end_frame;

    assign accept   = out_valid && out_ready;
    // Register is usable next cycle if empty now or being drained this edge.
    assign reg_free = !out_valid || out_ready;
    assign last_ch  = (channel_select == LAST_CH);
    // Done wins over a timeout that expires in the same cycle.
    assign capture  = (state == CONVERT) && (adc_done || timeout_expired);
    assign advance  = (state == RELEASE) && !adc_done && !last_ch;

    cycle_timer #(.LIMIT(settle_cycles)) u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state == SETTLE),
        .expired (settle_expired)
    );

    cycle_timer #(.LIMIT(timeout_cycles)) u_timeout_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state == CONVERT),
        .expired (timeout_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        end_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_expired && reg_free) state_next = CONVERT;
            end
            CONVERT: begin
                if (adc_done || timeout_expired) state_next = RELEASE;
            end
            RELEASE: begin
                if (!adc_done) begin
                    if (!last_ch) begin
                        state_next = SETTLE;
                    end else if (reg_free) begin
                        // Final word already gone or leaving now: DRAIN
                        // would only add a dead cycle before frame_done.
                        state_next = IDLE;
                        end_frame  = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (reg_free) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; both drop immediately on reset.
    always_comb begin
        adc_enable = (state == CONVERT);
        busy       = (state != IDLE);
    end

    // Channel counter, output register, status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            channel_select <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_channel    <= '0;
            out_error      <= 1'b0;
            error_sticky   <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= end_frame;

            if ((state == IDLE) && start) begin
                channel_select <= '0;
                error_sticky   <= 1'b0;
            end else if (advance) begin
                channel_select <= channel_select + CH_W'(1);
            end

            if (capture && !adc_done) error_sticky <= 1'b1;

            // CONVERT is only entered with the register free, so a capture
            // never overwrites an unaccepted word.
            if (capture) begin
                out_valid   <= 1'b1;
                out_channel <= channel_select;
                out_data    <= adc_done ? adc_result : '0;
                out_error   <= !adc_done;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
